// File: rtl/jedro_1_dmem.sv
// Data-memory responder for the jedro_1 LSU: request/grant/response handshake,
// one outstanding transaction, byte-lane writes and configurable wait states.
module jedro_1_dmem #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [31:0]             addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    gnt_o,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o
);

    localparam int unsigned Depth = 2 ** (ADDR_WIDTH - 2);
    localparam logic [3:0] CntLoad = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                  state_q;
    logic [3:0]              cnt_q;
    logic [DATA_WIDTH-1:0]   rbuf_q;
    logic                    ebuf_q;
    logic                    rvalid_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;

    logic [DATA_WIDTH-1:0]   mem [Depth];

    logic                    accept;
    logic                    be_legal;
    logic                    out_of_range;
    logic                    acc_err;
    logic [ADDR_WIDTH-3:0]   idx;
    logic [DATA_WIDTH-1:0]   load_data;
    logic                    unused_addr;

    assign unused_addr = ^addr_i[1:0];

    assign gnt_o  = req_i & ((state_q == StIdle) | (state_q == StResp)) & ~rst_i;
    assign accept = req_i & gnt_o;
    assign idx    = addr_i[ADDR_WIDTH-1:2];

    always_comb begin
        be_legal = 1'b0;
        case (be_i)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
            default:                   be_legal = 1'b0;
        endcase
    end

    // Shift rather than slice so the check stays well-formed for any ADDR_WIDTH.
    assign out_of_range = (addr_i >> ADDR_WIDTH) != 32'd0;
    assign acc_err      = ~be_legal | out_of_range;

    // Stores and errored accesses respond with zero data.
    assign load_data = (!we_i && !acc_err) ? mem[idx] : '0;

    always_ff @(posedge clk_i) begin
        if (accept && we_i && !acc_err) begin
            for (int n = 0; n < DATA_WIDTH / 8; n++) begin
                if (be_i[n]) begin
                    mem[idx][8*n +: 8] <= wdata_i[8*n +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            rbuf_q   <= '0;
            ebuf_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            case (state_q)
                StIdle, StResp: begin
                    if (accept) begin
                        rbuf_q <= load_data;
                        ebuf_q <= acc_err;
                        if (WAIT_STATES == 0) begin
                            state_q  <= StResp;
                            rvalid_q <= 1'b1;
                            rdata_q  <= load_data;
                            err_q    <= acc_err;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= CntLoad;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q  <= StResp;
                        rvalid_q <= 1'b1;
                        rdata_q  <= rbuf_q;
                        err_q    <= ebuf_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_jedro_1_dmem.sv
// Directed bench for jedro_1_dmem with three instances: WAIT_STATES = 1, 0 and 3.
module tb_jedro_1_dmem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        req0 = 1'b0, req1 = 1'b1, req3 = 1'b0;
    logic        gnt0, gnt1, gnt3;
    logic        rvalid0, rvalid1, rvalid3;
    logic        err0, err1, err3;
    logic [31:0] rdata0, rdata1, rdata3;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    jedro_1_dmem #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .WAIT_STATES(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we), .be_i(be), .addr_i(addr),
        .wdata_i(wdata), .gnt_o(gnt1), .rvalid_o(rvalid1), .rdata_o(rdata1), .err_o(err1)
    );

    jedro_1_dmem #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .WAIT_STATES(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req0), .we_i(we), .be_i(be), .addr_i(addr),
        .wdata_i(wdata), .gnt_o(gnt0), .rvalid_o(rvalid0), .rdata_o(rdata0), .err_o(err0)
    );

    jedro_1_dmem #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .WAIT_STATES(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .req_i(req3), .we_i(we), .be_i(be), .addr_i(addr),
        .wdata_i(wdata), .gnt_o(gnt3), .rvalid_o(rvalid3), .rdata_o(rdata3), .err_o(err3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction on the WAIT_STATES=1 instance: grant, one wait cycle, response.
    task automatic txn1(input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rdata,
                        input logic exp_err, input string tag);
        int n;
        @(negedge clk);
        we = w; be = b; addr = a; wdata = d; req1 = 1'b1;
        #1;
        n = 0;
        while (gnt1 !== 1'b1 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_gnt"}, 32'(gnt1), 32'd1);
        @(posedge clk);
        #1 req1 = 1'b0;
        chk({tag, "_wait_rvalid"}, 32'(rvalid1), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_rvalid"}, 32'(rvalid1), 32'd1);
        chk({tag, "_rdata"}, rdata1, exp_rdata);
        chk({tag, "_err"}, 32'(err1), 32'(exp_err));
        @(posedge clk);
        #1;
        chk({tag, "_after_rvalid"}, 32'(rvalid1), 32'd0);
        chk({tag, "_after_rdata"}, rdata1, 32'd0);
    endtask

    // Four back-to-back transactions on the WAIT_STATES=0 instance with req held high.
    task automatic b2b0(input logic w, input string tag);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (k < 4) begin
                req0 = 1'b1; we = w; be = 4'hF;
                addr = 32'h100 + 32'(4 * k);
                wdata = 32'hC0DE_0000 | 32'(k);
            end else begin
                req0 = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("%s_gnt%0d", tag, k), 32'(gnt0), 32'(k < 4));
            chk($sformatf("%s_rvalid%0d", tag, k), 32'(rvalid0), 32'(k > 0));
            if (k > 0) begin
                chk($sformatf("%s_rdata%0d", tag, k), rdata0,
                    w ? 32'd0 : (32'hC0DE_0000 | 32'(k - 1)));
            end
        end
        @(posedge clk);
        #1;
        chk({tag, "_end_rvalid"}, 32'(rvalid0), 32'd0);
    endtask

    initial begin : main
        logic [5:0] gpat;
        logic [5:0] rpat;
        logic       seen;
        int         n;

        // Reset state: grant masked by reset even with a request present.
        #2;
        chk("rst_gnt1", 32'(gnt1), 32'd0);
        chk("rst_rvalid1", 32'(rvalid1), 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        chk("rst_err1", 32'(err1), 32'd0);
        chk("rst_rvalid3", 32'(rvalid3), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0; req1 = 1'b0;

        txn1(1'b1, 4'hF, 32'h010, 32'hDEAD_BEEF, 32'h0, 1'b0, "st_word");
        txn1(1'b0, 4'hF, 32'h010, 32'h0, 32'hDEAD_BEEF, 1'b0, "ld_word");
        txn1(1'b1, 4'h4, 32'h010, 32'h00AA_0000, 32'h0, 1'b0, "st_byte");
        txn1(1'b0, 4'h1, 32'h010, 32'h0, 32'hDEAA_BEEF, 1'b0, "ld_byte");
        txn1(1'b1, 4'hC, 32'h010, 32'h1234_0000, 32'h0, 1'b0, "st_half");
        txn1(1'b0, 4'hF, 32'h013, 32'h0, 32'h1234_BEEF, 1'b0, "ld_half_unaligned");
        txn1(1'b1, 4'h5, 32'h010, 32'hFFFF_FFFF, 32'h0, 1'b1, "st_be0101");
        txn1(1'b1, 4'h0, 32'h010, 32'hFFFF_FFFF, 32'h0, 1'b1, "st_be0000");
        txn1(1'b0, 4'hF, 32'h010, 32'h0, 32'h1234_BEEF, 1'b0, "ld_after_illegal");
        txn1(1'b0, 4'h5, 32'h010, 32'h0, 32'h0, 1'b1, "ld_be0101");
        txn1(1'b1, 4'hF, 32'h004, 32'h1111_2222, 32'h0, 1'b0, "st_w1");
        txn1(1'b0, 4'hF, 32'h1000, 32'h0, 32'h0, 1'b1, "ld_oor");
        txn1(1'b1, 4'hF, 32'h1004, 32'hFFFF_FFFF, 32'h0, 1'b1, "st_oor");
        txn1(1'b1, 4'hF, 32'h8000_0010, 32'hFFFF_FFFF, 32'h0, 1'b1, "st_oor_hi");
        txn1(1'b0, 4'hF, 32'h004, 32'h0, 32'h1111_2222, 1'b0, "ld_w1_after_oor");
        txn1(1'b0, 4'hF, 32'h010, 32'h0, 32'h1234_BEEF, 1'b0, "ld_w4_after_oor");

        b2b0(1'b1, "b2b_st");
        b2b0(1'b0, "b2b_ld");

        // WAIT_STATES=3 with req held: grants in cycles 0 and 4, response in cycle 4.
        @(posedge clk);
        #1 req3 = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h020; wdata = 32'h77;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            gpat[k] = gnt3;
            rpat[k] = rvalid3;
        end
        @(posedge clk);
        #1 req3 = 1'b0;
        chk("ws3_gnt_pattern", 32'(gpat), 32'h11);
        chk("ws3_rvalid_pattern", 32'(rpat), 32'h10);
        repeat (6) @(posedge clk);

        // Reset one cycle after a store grant drops the response but keeps the write.
        @(posedge clk);
        #1 req3 = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h030; wdata = 32'h55;
        @(negedge clk);
        chk("rstw_gnt", 32'(gnt3), 32'd1);
        @(posedge clk);
        #1 req3 = 1'b0; rst = 1'b1;
        #1;
        chk("rstw_rvalid", 32'(rvalid3), 32'd0);
        chk("rstw_rdata", rdata3, 32'd0);
        chk("rstw_err", 32'(err3), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rvalid3 !== 1'b0) seen = 1'b1;
        end
        chk("rstw_no_rvalid", 32'(seen), 32'd0);
        @(posedge clk);
        #1 req3 = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h030;
        @(negedge clk);
        chk("rstw_ld_gnt", 32'(gnt3), 32'd1);
        @(posedge clk);
        #1 req3 = 1'b0;
        n = 0;
        while (rvalid3 !== 1'b1 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rstw_ld_latency", 32'(n), 32'd3);
        chk("rstw_ld_rdata", rdata3, 32'h55);
        chk("rstw_ld_err", 32'(err3), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jedro_1_dmem.md
# jedro_1_dmem

Single-port data-memory responder for the jedro_1 core. It answers load/store requests issued by the load-store unit over a request/grant/response handshake, with a single outstanding transaction. Byte-lane writes are applied under byte enables, and responses are delayed by a configurable number of wait states. The block sits on the core's data port, opposite the LSU, and is the target end of the data-memory interface.

## Interface
Parameters:
- DATA_WIDTH, 32: data bus width; only 32 is supported.
- ADDR_WIDTH, 12: number of byte-address bits decoded. Memory depth is 2**(ADDR_WIDTH-2) words.
- WAIT_STATES, 1: extra cycles between grant and response; legal range is 0 to 15.

Ports:
- clk_i  input  1  clock. All logic is rising-edge.
- rst_i  input  1  reset, asynchronous, active-high.
- req_i  input  1  request valid. The LSU holds the request stable until it sees gnt_o.
- we_i  input  1  1 = store, 0 = load.
- be_i  input  4  byte enables; lane n is bits [8n+7:8n].
- addr_i  input  32  byte address.
- wdata_i  input  32  store data, already lane-aligned.
- gnt_o  output  1  request accepted this cycle.
- rvalid_o  output  1  response valid; one-cycle pulse per transaction.
- rdata_o  output  32  load data, valid while rvalid_o is high.
- err_o  output  1  response error, valid while rvalid_o is high.

## Operation
- FSM states: IDLE, WAIT, RESP.
- gnt_o = req_i & (state == IDLE | state == RESP) & !rst_i. It is the only combinational output.
- On an accepting edge (req_i & gnt_o):
  - Decode the access.
  - For a legal store, write the enabled lanes of wdata_i into mem[addr_i[ADDR_WIDTH-1:2]].
  - For a legal load, capture the full word into the read buffer. The read occurs before any write on the same edge.
  - Latch the error flag.
- Next state after acceptance: WAIT with counter = WAIT_STATES-1 if WAIT_STATES > 0, otherwise RESP.
- WAIT: the counter decrements each cycle. When the counter is 0, go to RESP.
- RESP: rvalid_o = 1. The state then becomes IDLE, or re-enters WAIT/RESP if a new request is accepted in the same cycle.
- Legal be_i values: 0001, 0010, 0100, 1000, 0011, 1100, 1111. Any other value, including 0000, is illegal.
- Out of range: addr_i[31:ADDR_WIDTH] != 0.
- Error response (illegal be_i or out of range):
  - No memory write.
  - err_o = 1 and rdata_o = 0 during the response.
- addr_i[1:0] is ignored. Lane selection comes only from be_i.
- Load data returns the full 32-bit word regardless of be_i. The LSU performs extraction and extension.
- Store response: rdata_o = 0 and err_o = 0 unless the store was an error.
- Memory contents are not reset.

## Timing
- Reset values: gnt_o = 0, rvalid_o = 0, rdata_o = 0, err_o = 0, state = IDLE, counter = 0.
- Latency: a request granted in cycle T gets its response (rvalid_o high) in cycle T+1+WAIT_STATES.
- Throughput:
  - WAIT_STATES = 0: one transaction per cycle. gnt_o and rvalid_o are high together in back-to-back operation.
  - Otherwise: one transaction per 1+WAIT_STATES cycles.
- While in WAIT, gnt_o = 0 even if req_i is high. The request stays pending.
- rdata_o and err_o are registered. Outside rvalid_o they hold 0.
- Store then load to the same word in consecutive transactions: the load returns the new data.
- Reset asserted mid-transaction:
  - Outputs clear immediately.
  - The pending response is dropped.
  - A store already committed at its grant edge remains in memory.
- Counter width is 4 bits and it does not wrap: it is reloaded only on acceptance.

## Test plan
- Word store then load, WAIT_STATES=1: store 0xDEADBEEF to 0x010 with be 1111 -> gnt in T, rvalid in T+2 with err=0. Then load 0x010 -> rdata 0xDEADBEEF.
- Byte merge: store 0x00AA0000 with be 0100 to 0x010 holding 0xDEADBEEF -> a subsequent load returns 0xDEAABEEF. A halfword store of 0x12340000 with be 1100 -> the word reads 0x1234BEEF.
- Illegal enables: store with be 0101 or 0000 -> err=1, rdata=0, memory unchanged on readback.
- Out of range, ADDR_WIDTH=12: load 0x1000 -> err=1, rdata=0. A store to 0x1004 leaves every in-range word unchanged.
- Back-to-back, WAIT_STATES=0: req_i held high for 4 distinct loads -> gnt high for 4 consecutive cycles and rvalid high for 4 consecutive cycles, offset by 1, with data in order. With WAIT_STATES=3: gnt is low for 3 cycles between grants.
- Reset during WAIT, WAIT_STATES=3: assert rst_i one cycle after the grant of a store of 0x55 -> rvalid never pulses and outputs are 0. After release, a load of that word returns 0x55.
